// File: rtl/nway_cache_control.sv
`default_nettype none
// ============================================================================
// nway_cache_control : WAYS-way write-back/write-allocate L2 control FSM with
//                      tree pseudo-LRU replacement and full-cache flush.
// Revision: 1.0
// ============================================================================
module nway_cache_control #(
  parameter int WAYS     = 4,
  parameter int WAY_BITS = $clog2(WAYS),
  parameter int SET_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  input  logic                hit,
  input  logic [WAYS-1:0]     hit_way,
  input  logic [WAYS-1:0]     valid_out,
  input  logic [WAYS-1:0]     dirty_out,
  input  logic [WAYS-2:0]     lru_out,
  output logic [WAYS-2:0]     lru_in,
  output logic                ld_lru,
  output logic [WAYS-1:0]     ld_valid,
  output logic                valid_in,
  output logic [WAYS-1:0]     ld_dirty,
  output logic                dirty_in,
  output logic [WAYS-1:0]     ld_tag,
  output logic [WAYS-1:0]     ld_data,
  output logic                write_mux_sel,
  output logic [WAY_BITS-1:0] pmem_way_sel,
  output logic                pmem_addr_sel,
  output logic                index_sel,
  output logic [SET_BITS-1:0] flush_index
);

  localparam logic [WAY_BITS-1:0] c_last_way = WAY_BITS'(WAYS - 1);
  localparam logic [SET_BITS-1:0] c_last_set = {SET_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EVICT    = 3'd1,
    FETCH    = 3'd2,
    FL_CHECK = 3'd3,
    FL_EVICT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAY_BITS-1:0] r_way;
  logic [SET_BITS-1:0] r_set;
  logic                w_advance;
  logic [WAY_BITS-1:0] w_victim;
  logic [WAY_BITS-1:0] w_hit_idx;
  logic [WAYS-1:0]     w_victim_oh;
  logic [WAYS-1:0]     w_way_oh;
  logic                w_last_way;
  logic                w_last_set;

  // Heap-ordered tree: node n lives in bit n-1; each node on the path is
  // pointed away from the accessed way.
  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] tree,
                                                  input logic [WAY_BITS-1:0] way);
    logic [WAYS-2:0] t;
    int              node;
    t    = tree;
    node = 1;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      t[node-1] = ~way[l];
      node      = 2 * node + int'(way[l]);
    end
    return t;
  endfunction

  // Lowest invalid way wins; otherwise follow the tree from the root.
  function automatic logic [WAY_BITS-1:0] pick_victim(input logic [WAYS-1:0] valid,
                                                      input logic [WAYS-2:0] tree);
    logic [WAY_BITS-1:0] v;
    logic                b;
    int                  node;
    v    = '0;
    node = 1;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      b    = tree[node-1];
      v[l] = b;
      node = 2 * node + int'(b);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) v = WAY_BITS'(w);
    end
    return v;
  endfunction

  function automatic logic [WAY_BITS-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_BITS-1:0] idx;
    idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (oh[w]) idx = idx | WAY_BITS'(w);
    end
    return idx;
  endfunction

  assign w_victim    = pick_victim(valid_out, lru_out);
  assign w_hit_idx   = onehot_to_idx(hit_way);
  assign w_victim_oh = WAYS'(1) << w_victim;
  assign w_way_oh    = WAYS'(1) << r_way;
  assign w_last_way  = (r_way == c_last_way);
  assign w_last_set  = (r_set == c_last_set);
  assign flush_index = r_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_way   <= '0;
      r_set   <= '0;
    end else begin
      r_state <= w_next;
      if (w_advance) begin
        r_way <= r_way + 1'b1;
        if (w_last_way) r_set <= r_set + 1'b1;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_advance     = 1'b0;
    mem_resp      = 1'b0;
    flush_done    = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    lru_in        = '0;
    ld_lru        = 1'b0;
    ld_valid      = '0;
    valid_in      = 1'b0;
    ld_dirty      = '0;
    dirty_in      = 1'b0;
    ld_tag        = '0;
    ld_data       = '0;
    write_mux_sel = 1'b0;
    pmem_way_sel  = '0;
    pmem_addr_sel = 1'b0;
    index_sel     = 1'b0;

    // Outputs are held low for the whole time reset is asserted.
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (mem_read || mem_write) begin
            if (hit) begin
              mem_resp = 1'b1;
              ld_lru   = 1'b1;
              lru_in   = plru_update(lru_out, w_hit_idx);
              if (mem_write) begin
                write_mux_sel = 1'b1;
                ld_data       = hit_way;
                ld_dirty      = hit_way;
                ld_tag        = hit_way;
                dirty_in      = 1'b1;
              end
            end else if (valid_out[w_victim] && dirty_out[w_victim]) begin
              w_next = EVICT;
            end else begin
              w_next = FETCH;
            end
          end else if (flush_req) begin
            w_next = FL_CHECK;
          end
        end
        EVICT: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          pmem_way_sel  = w_victim;
          if (pmem_resp) w_next = FETCH;
        end
        FETCH: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            ld_valid = w_victim_oh;
            ld_dirty = w_victim_oh;
            ld_tag   = w_victim_oh;
            ld_data  = w_victim_oh;
            valid_in = 1'b1;
            ld_lru   = 1'b1;
            lru_in   = plru_update(lru_out, w_victim);
            w_next   = IDLE;
          end
        end
        FL_CHECK: begin
          index_sel = 1'b1;
          if (valid_out[r_way] && dirty_out[r_way]) begin
            w_next = FL_EVICT;
          end else begin
            ld_valid  = w_way_oh;
            w_advance = 1'b1;
          end
        end
        FL_EVICT: begin
          index_sel     = 1'b1;
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          pmem_way_sel  = r_way;
          if (pmem_resp) begin
            ld_valid  = w_way_oh;
            ld_dirty  = w_way_oh;
            w_advance = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase

      if (w_advance) begin
        w_next = FL_CHECK;
        if (w_last_way) begin
          ld_lru = 1'b1;
          lru_in = '0;
          if (w_last_set) begin
            flush_done = 1'b1;
            w_next     = IDLE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nway_cache_control.sv
`default_nettype none
// ============================================================================
// tb_nway_cache_control : directed bench for 4-, 8- and 2-way configurations.
// Revision: 1.0
// ============================================================================
module tb_nway_cache_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // ---------------- 4-way, 8 sets ----------------
  logic       mem_read4 = 0, mem_write4 = 0, flush_req4 = 0, pmem_resp4 = 0, hit4 = 0;
  logic [3:0] hit_way4 = 0, valid_out4 = 0, dirty_out4 = 0;
  logic [2:0] lru_out4 = 0;
  logic       mem_resp4, flush_done4, pmem_read4, pmem_write4, ld_lru4, valid_in4, dirty_in4;
  logic       write_mux_sel4, pmem_addr_sel4, index_sel4;
  logic [2:0] lru_in4, flush_index4;
  logic [3:0] ld_valid4, ld_dirty4, ld_tag4, ld_data4;
  logic [1:0] pmem_way_sel4;

  nway_cache_control #(.WAYS(4), .SET_BITS(3)) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read4), .mem_write(mem_write4), .mem_resp(mem_resp4),
    .flush_req(flush_req4), .flush_done(flush_done4), .pmem_read(pmem_read4),
    .pmem_write(pmem_write4), .pmem_resp(pmem_resp4), .hit(hit4), .hit_way(hit_way4),
    .valid_out(valid_out4), .dirty_out(dirty_out4), .lru_out(lru_out4), .lru_in(lru_in4),
    .ld_lru(ld_lru4), .ld_valid(ld_valid4), .valid_in(valid_in4), .ld_dirty(ld_dirty4),
    .dirty_in(dirty_in4), .ld_tag(ld_tag4), .ld_data(ld_data4), .write_mux_sel(write_mux_sel4),
    .pmem_way_sel(pmem_way_sel4), .pmem_addr_sel(pmem_addr_sel4), .index_sel(index_sel4),
    .flush_index(flush_index4)
  );

  wire any4 = |{mem_resp4, flush_done4, pmem_read4, pmem_write4, lru_in4, ld_lru4, ld_valid4,
                valid_in4, ld_dirty4, dirty_in4, ld_tag4, ld_data4, write_mux_sel4,
                pmem_way_sel4, pmem_addr_sel4, index_sel4, flush_index4};
  wire any_ld4 = |{ld_valid4, ld_dirty4, ld_tag4, ld_data4, ld_lru4};

  // ---------------- 8-way, 8 sets ----------------
  logic       mem_read8 = 0, pmem_resp8 = 0;
  logic [7:0] valid_out8 = 0, dirty_out8 = 0;
  logic [6:0] lru_out8 = 0;
  logic       mem_resp8, flush_done8, pmem_read8, pmem_write8, ld_lru8, valid_in8, dirty_in8;
  logic       write_mux_sel8, pmem_addr_sel8, index_sel8;
  logic [6:0] lru_in8;
  logic [2:0] flush_index8, pmem_way_sel8;
  logic [7:0] ld_valid8, ld_dirty8, ld_tag8, ld_data8;

  nway_cache_control #(.WAYS(8), .SET_BITS(3)) dut8 (
    .clk(clk), .rst(rst), .mem_read(mem_read8), .mem_write(1'b0), .mem_resp(mem_resp8),
    .flush_req(1'b0), .flush_done(flush_done8), .pmem_read(pmem_read8),
    .pmem_write(pmem_write8), .pmem_resp(pmem_resp8), .hit(1'b0), .hit_way(8'h00),
    .valid_out(valid_out8), .dirty_out(dirty_out8), .lru_out(lru_out8), .lru_in(lru_in8),
    .ld_lru(ld_lru8), .ld_valid(ld_valid8), .valid_in(valid_in8), .ld_dirty(ld_dirty8),
    .dirty_in(dirty_in8), .ld_tag(ld_tag8), .ld_data(ld_data8), .write_mux_sel(write_mux_sel8),
    .pmem_way_sel(pmem_way_sel8), .pmem_addr_sel(pmem_addr_sel8), .index_sel(index_sel8),
    .flush_index(flush_index8)
  );

  // ---------------- 2-way, 2 sets, with a small tag-store model ----------------
  logic       flush_req2 = 0, pmem_resp2 = 0, model_init = 0;
  logic [1:0] valid_out2, dirty_out2;
  logic       mem_resp2, flush_done2, pmem_read2, pmem_write2, ld_lru2, valid_in2, dirty_in2;
  logic       write_mux_sel2, pmem_addr_sel2, index_sel2, flush_index2, pmem_way_sel2;
  logic [0:0] lru_in2;
  logic [1:0] ld_valid2, ld_dirty2, ld_tag2, ld_data2;
  logic [3:0] vm, dm;  // bit {set, way}
  wire        idx2 = index_sel2 ? flush_index2 : 1'b0;

  assign valid_out2 = {vm[{idx2, 1'b1}], vm[{idx2, 1'b0}]};
  assign dirty_out2 = {dm[{idx2, 1'b1}], dm[{idx2, 1'b0}]};

  always @(posedge clk) begin
    if (model_init) begin
      vm <= 4'b1111;
      dm <= 4'b1000;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (ld_valid2[w]) vm[{idx2, w[0]}] <= valid_in2;
        if (ld_dirty2[w]) dm[{idx2, w[0]}] <= dirty_in2;
      end
    end
  end

  nway_cache_control #(.WAYS(2), .SET_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .mem_read(1'b0), .mem_write(1'b0), .mem_resp(mem_resp2),
    .flush_req(flush_req2), .flush_done(flush_done2), .pmem_read(pmem_read2),
    .pmem_write(pmem_write2), .pmem_resp(pmem_resp2), .hit(1'b0), .hit_way(2'b00),
    .valid_out(valid_out2), .dirty_out(dirty_out2), .lru_out(1'b1), .lru_in(lru_in2),
    .ld_lru(ld_lru2), .ld_valid(ld_valid2), .valid_in(valid_in2), .ld_dirty(ld_dirty2),
    .dirty_in(dirty_in2), .ld_tag(ld_tag2), .ld_data(ld_data2), .write_mux_sel(write_mux_sel2),
    .pmem_way_sel(pmem_way_sel2), .pmem_addr_sel(pmem_addr_sel2), .index_sel(index_sel2),
    .flush_index(flush_index2)
  );

  task automatic test_reset;
    mem_read4 = 1; mem_write4 = 1; hit4 = 1; hit_way4 = 4'b0001; flush_req4 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (any4 !== 1'b0) begin n_fail++; $display("FAIL reset_outputs4: got nonzero, want all 0"); end
    n_tests++; if (mem_resp4 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp4: got %b want 0", mem_resp4); end
    n_tests++; if ({pmem_read8, ld_valid8, ld_lru8, index_sel8} !== 10'h0) begin n_fail++; $display("FAIL reset_outputs8: got nonzero, want 0"); end
    n_tests++; if ({pmem_write2, ld_valid2, flush_done2, index_sel2} !== 5'h0) begin n_fail++; $display("FAIL reset_outputs2: got nonzero, want 0"); end
    mem_read4 = 0; mem_write4 = 0; hit4 = 0; hit_way4 = 0; flush_req4 = 0;
    rst = 0;
  endtask

  task automatic test_reset_mid_fetch;
    @(negedge clk);
    mem_read4 = 1; hit4 = 0; valid_out4 = 4'hF; dirty_out4 = 0; lru_out4 = 0;
    @(negedge clk); #1;
    n_tests++; if (pmem_read4 !== 1'b1) begin n_fail++; $display("FAIL midfetch_pmem_read: got %b want 1", pmem_read4); end
    pmem_resp4 = 1;
    rst = 1; #1;
    n_tests++; if (any4 !== 1'b0) begin n_fail++; $display("FAIL midfetch_reset_outputs: got nonzero, want all 0"); end
    @(negedge clk);
    mem_read4 = 0; pmem_resp4 = 0; rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++; if ({any_ld4, pmem_read4} !== 2'b00) begin n_fail++; $display("FAIL midfetch_post_reset_cycle%0d: ld/pmem_read=%b want 00", i, {any_ld4, pmem_read4}); end
    end
  endtask

  task automatic test_read_miss;
    @(negedge clk);
    mem_read4 = 1; hit4 = 0; valid_out4 = 4'hF; dirty_out4 = 0; lru_out4 = 3'b000; #1;
    n_tests++; if ({mem_resp4, pmem_read4, pmem_write4} !== 3'b000) begin n_fail++; $display("FAIL rmiss_idle: got %b want 000", {mem_resp4, pmem_read4, pmem_write4}); end
    @(negedge clk); #1;
    n_tests++; if ({pmem_read4, pmem_addr_sel4, ld_data4} !== 6'b100000) begin n_fail++; $display("FAIL rmiss_fetch_wait: got %b want 100000", {pmem_read4, pmem_addr_sel4, ld_data4}); end
    pmem_resp4 = 1; #1;
    n_tests++; if (ld_data4 !== 4'b0001) begin n_fail++; $display("FAIL rmiss_ld_data: got %b want 0001", ld_data4); end
    n_tests++; if ({ld_valid4, ld_tag4, ld_dirty4} !== 12'b0001_0001_0001) begin n_fail++; $display("FAIL rmiss_ld_vtd: got %b", {ld_valid4, ld_tag4, ld_dirty4}); end
    n_tests++; if ({valid_in4, dirty_in4, ld_lru4, lru_in4} !== 6'b101011) begin n_fail++; $display("FAIL rmiss_lru_vals: got %b want 101011", {valid_in4, dirty_in4, ld_lru4, lru_in4}); end
    @(negedge clk);
    pmem_resp4 = 0; hit4 = 1; hit_way4 = 4'b0001; #1;
    n_tests++; if ({mem_resp4, ld_lru4, lru_in4, ld_data4} !== 9'b1_1_011_0000) begin n_fail++; $display("FAIL rmiss_then_hit: got %b want 110110000", {mem_resp4, ld_lru4, lru_in4, ld_data4}); end
    @(negedge clk);
    mem_read4 = 0; hit4 = 0; hit_way4 = 0;
  endtask

  task automatic test_write_miss_dirty;
    @(negedge clk);
    mem_write4 = 1; hit4 = 0; valid_out4 = 4'hF; dirty_out4 = 4'b0100; lru_out4 = 3'b001; #1;
    n_tests++; if ({mem_resp4, pmem_write4} !== 2'b00) begin n_fail++; $display("FAIL wmiss_idle: got %b want 00", {mem_resp4, pmem_write4}); end
    @(negedge clk); #1;
    n_tests++; if ({pmem_write4, pmem_addr_sel4, pmem_way_sel4, pmem_read4} !== 5'b11100) begin n_fail++; $display("FAIL wmiss_evict: got %b want 11100", {pmem_write4, pmem_addr_sel4, pmem_way_sel4, pmem_read4}); end
    pmem_resp4 = 1;
    @(negedge clk);
    pmem_resp4 = 0; #1;
    n_tests++; if ({pmem_read4, pmem_write4, pmem_addr_sel4} !== 3'b100) begin n_fail++; $display("FAIL wmiss_fetch: got %b want 100", {pmem_read4, pmem_write4, pmem_addr_sel4}); end
    pmem_resp4 = 1; #1;
    n_tests++; if ({ld_tag4, ld_valid4} !== 8'b0100_0100) begin n_fail++; $display("FAIL wmiss_fill_way: got %b want 01000100", {ld_tag4, ld_valid4}); end
    n_tests++; if (lru_in4 !== 3'b100) begin n_fail++; $display("FAIL wmiss_fill_lru: got %b want 100", lru_in4); end
    @(negedge clk);
    pmem_resp4 = 0; hit4 = 1; hit_way4 = 4'b0100; #1;
    n_tests++; if ({mem_resp4, ld_dirty4, dirty_in4, write_mux_sel4} !== 7'b1_0100_1_1) begin n_fail++; $display("FAIL whit_dirty: got %b want 1010011", {mem_resp4, ld_dirty4, dirty_in4, write_mux_sel4}); end
    n_tests++; if ({ld_data4, ld_tag4, ld_valid4, lru_in4} !== 15'b0100_0100_0000_100) begin n_fail++; $display("FAIL whit_strobes: got %b", {ld_data4, ld_tag4, ld_valid4, lru_in4}); end
    @(negedge clk);
    mem_write4 = 0; hit4 = 0; hit_way4 = 0; dirty_out4 = 0;
  endtask

  task automatic test_victim_invalid_way;
    logic [6:0] lrus [2];
    logic [6:0] exp_lru [2];
    lrus[0] = 7'h7F; exp_lru[0] = 7'h5E;
    lrus[1] = 7'h00; exp_lru[1] = 7'h04;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_read8 = 1; valid_out8 = 8'hDF; dirty_out8 = 8'hFF; lru_out8 = lrus[k];
      @(negedge clk); #1;
      n_tests++; if ({pmem_read8, pmem_write8} !== 2'b10) begin n_fail++; $display("FAIL v8_fetch_%0d: got %b want 10", k, {pmem_read8, pmem_write8}); end
      pmem_resp8 = 1; #1;
      n_tests++; if (ld_valid8 !== 8'h20) begin n_fail++; $display("FAIL v8_ld_valid_%0d: got %h want 20", k, ld_valid8); end
      n_tests++; if (lru_in8 !== exp_lru[k]) begin n_fail++; $display("FAIL v8_lru_in_%0d: got %h want %h", k, lru_in8, exp_lru[k]); end
      @(negedge clk);
      pmem_resp8 = 0; mem_read8 = 0;
    end
  endtask

  task automatic test_flush;
    int   wcnt = 0, n_ldv = 0, n_badv = 0, n_wseq = 0, n_badw = 0, n_lruclr = 0, n_done = 0;
    logic prev_w = 0;
    @(negedge clk); model_init = 1;
    @(negedge clk); model_init = 0; flush_req2 = 1;
    for (int cyc = 0; cyc < 40 && n_done == 0; cyc++) begin
      @(negedge clk);
      wcnt = pmem_write2 ? wcnt + 1 : 0;
      pmem_resp2 = (wcnt == 3);
      #1;
      if (ld_valid2 != 2'b00) begin
        n_ldv += $countones(ld_valid2);
        if (valid_in2 !== 1'b0) n_badv++;
      end
      if (pmem_write2 && !prev_w) n_wseq++;
      if (pmem_write2 && {flush_index2, pmem_way_sel2, pmem_addr_sel2} !== 3'b111) n_badw++;
      prev_w = pmem_write2;
      if (ld_lru2 && lru_in2 === 1'b0) n_lruclr++;
      if (flush_done2) n_done++;
    end
    @(negedge clk);
    flush_req2 = 0; pmem_resp2 = 0; #1;
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL flush_done_count: got %0d want 1", n_done); end
    n_tests++; if (flush_done2 !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse: got %b want 0", flush_done2); end
    n_tests++; if (n_wseq !== 1) begin n_fail++; $display("FAIL flush_wb_count: got %0d want 1", n_wseq); end
    n_tests++; if (n_badw !== 0) begin n_fail++; $display("FAIL flush_wb_addr: got %0d bad cycles want 0", n_badw); end
    n_tests++; if (n_ldv !== 4) begin n_fail++; $display("FAIL flush_ld_valid_count: got %0d want 4", n_ldv); end
    n_tests++; if (n_badv !== 0) begin n_fail++; $display("FAIL flush_valid_in: got %0d bad want 0", n_badv); end
    n_tests++; if (n_lruclr !== 2) begin n_fail++; $display("FAIL flush_lru_clear: got %0d want 2", n_lruclr); end
    n_tests++; if ({vm, dm} !== 8'h00) begin n_fail++; $display("FAIL flush_model_state: got %h want 00", {vm, dm}); end
  endtask

  task automatic test_priority;
    int n_fl = 0, n_resp = 0, n_done = 0;
    @(negedge clk);
    flush_req4 = 1; mem_read4 = 1; hit4 = 1; hit_way4 = 4'b0010;
    valid_out4 = 0; dirty_out4 = 0; lru_out4 = 0; #1;
    n_tests++; if ({mem_resp4, index_sel4, lru_in4} !== 5'b10001) begin n_fail++; $display("FAIL prio_read_first: got %b want 10001", {mem_resp4, index_sel4, lru_in4}); end
    @(negedge clk);
    mem_read4 = 0; hit4 = 0; #1;
    n_tests++; if ({mem_resp4, index_sel4} !== 2'b00) begin n_fail++; $display("FAIL prio_still_idle: got %b want 00", {mem_resp4, index_sel4}); end
    for (int cyc = 0; cyc < 100 && n_done == 0; cyc++) begin
      @(negedge clk);
      mem_read4 = 1; hit4 = 1; #1;
      if (index_sel4) n_fl++;
      if (mem_resp4) n_resp++;
      if (flush_done4) n_done++;
    end
    @(negedge clk);
    flush_req4 = 0; mem_read4 = 0; hit4 = 0; hit_way4 = 0; #1;
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL prio_flush_done: got %0d want 1", n_done); end
    n_tests++; if (n_fl !== 32) begin n_fail++; $display("FAIL prio_flush_cycles: got %0d want 32", n_fl); end
    n_tests++; if (n_resp !== 0) begin n_fail++; $display("FAIL prio_resp_during_flush: got %0d want 0", n_resp); end
    n_tests++; if ({flush_done4, flush_index4, index_sel4} !== 5'b0) begin n_fail++; $display("FAIL prio_after_flush: got %b want 00000", {flush_done4, flush_index4, index_sel4}); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_read_miss();
    test_write_miss_dirty();
    test_victim_invalid_way();
    test_flush();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nway_cache_control.md
Name: nway_cache_control

Overview:
Parametrised control FSM for a WAYS-way set-associative, write-back, write-allocate L2 cache, sitting between the arbiter and physical memory. It drives the per-way valid/dirty/tag/data load strobes and the tree pseudo-LRU state of an external cache datapath. It generalises the fixed 4-way controller to any power-of-two way count. It adds asynchronous reset and a full-cache flush mode that writes back and invalidates every line.

Parameters:
WAYS, 4, number of ways; power of two, 2..16
WAY_BITS, $clog2(WAYS), width of a way index
SET_BITS, 3, log2 of the number of sets (index width)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_read  in  1  arbiter read request, held until mem_resp
mem_write  in  1  arbiter write request, held until mem_resp
mem_resp  out  1  request complete
flush_req  in  1  request a full flush; held until flush_done
flush_done  out  1  one-cycle pulse when the flush completes
pmem_read  out  1  line read from physical memory
pmem_write  out  1  line write to physical memory
pmem_resp  in  1  physical memory transfer complete
hit  in  1  tag match on a valid way at the current index
hit_way  in  WAYS  one-hot matching way
valid_out  in  WAYS  valid bits of the current set
dirty_out  in  WAYS  dirty bits of the current set
lru_out  in  WAYS-1  PLRU tree bits of the current set
lru_in  out  WAYS-1  new PLRU tree bits
ld_lru  out  1  load lru_in
ld_valid  out  WAYS  per-way valid load strobe
valid_in  out  1  valid value written
ld_dirty  out  WAYS  per-way dirty load strobe
dirty_in  out  1  dirty value written
ld_tag  out  WAYS  per-way tag load strobe
ld_data  out  WAYS  per-way data load strobe
write_mux_sel  out  1  0: line from pmem; 1: merge write data from the arbiter
pmem_way_sel  out  WAY_BITS  way whose tag/data go to pmem on a write-back
pmem_addr_sel  out  1  0: arbiter address; 1: {tag[pmem_way_sel], index}
index_sel  out  1  0: arbiter index; 1: flush_index
flush_index  out  SET_BITS  set currently being flushed

Behaviour:
- Reset (async, rst=1): state=IDLE; way and set counters are 0. All outputs are 0 while in reset and whenever no state asserts them. Reset mid-transfer abandons the transfer with no strobes asserted.
- PLRU layout: heap order, node n (1..WAYS-1) is stored in bit n-1; children of node n are 2n and 2n+1.
  - Node bit 0: the victim lies in the lower half. Node bit 1: the victim lies in the upper half.
  - Access update: every node on the path to the accessed way is set to point away from it. Nodes off the path are unchanged.
- Victim selection: the lowest-index way with valid_out=0. If all ways are valid, walk the tree from the root.
- States: IDLE, EVICT, FETCH, FL_CHECK, FL_EVICT.
- IDLE:
  - When hit and (mem_read or mem_write): mem_resp=1 in the same cycle, ld_lru=1, lru_in = update(hit_way).
  - On a write hit, additionally: write_mux_sel=1, and ld_data, ld_dirty and ld_tag of the hit way are asserted with dirty_in=1.
  - On a miss with a request: go to EVICT if the victim is valid and dirty, else go to FETCH.
  - If there is no request and flush_req=1: go to FL_CHECK. Demand requests take priority over flush.
- EVICT: pmem_write=1, pmem_addr_sel=1, pmem_way_sel=victim. On pmem_resp, go to FETCH.
- FETCH: pmem_read=1, pmem_addr_sel=0. On pmem_resp:
  - Load the victim's ld_valid, ld_dirty, ld_tag and ld_data with valid_in=1, dirty_in=0.
  - ld_lru=1, lru_in = update(victim).
  - Go to IDLE. The request then hits on the next cycle.
- FL_CHECK: index_sel=1; way w is the way counter.
  - If valid_out[w] and dirty_out[w]: go to FL_EVICT.
  - Otherwise: ld_valid[w]=1, valid_in=0, then advance.
- FL_EVICT: index_sel=1, pmem_write=1, pmem_addr_sel=1, pmem_way_sel=w. On pmem_resp: clear valid and dirty of w (both strobes, values 0), then advance.
- Advance: increment w. When w wraps from WAYS-1 to 0, also assert ld_lru with lru_in=0 for that set and increment flush_index.
  - On the last set's last way: flush_done=1 for that cycle, return to IDLE, counters reset to 0.
  - While flushing, mem_read/mem_write are ignored; mem_resp stays 0.
- A pmem_resp arriving in IDLE or FL_CHECK is ignored.

Test Plan:
- Reset mid-FETCH with pmem_read=1 -> all outputs 0 immediately and state IDLE; no ld_* pulse after reset is released.
- WAYS=4, set fully valid and clean, lru_out=3'b000, read miss -> victim way 0, FETCH; on pmem_resp: ld_data=4'b0001, lru_in=3'b011; next cycle hit -> mem_resp=1.
- WAYS=4, all valid, way 2 dirty, lru_out=3'b001 (victim way 2), write miss -> EVICT with pmem_way_sel=2, pmem_addr_sel=1, then FETCH, then write hit: ld_dirty=4'b0100, dirty_in=1, write_mux_sel=1.
- WAYS=8, valid_out=8'hDF -> victim way 5 regardless of lru_out; fill writes ld_valid=8'h20.
- Flush with SET_BITS=1, WAYS=2, only set 1 way 1 dirty -> exactly one pmem_write sequence with flush_index=1, pmem_way_sel=1; flush_done pulses once after 4 way visits; every ld_valid is pulsed with valid_in=0.
- flush_req and mem_read asserted together in IDLE -> the read is serviced first; the flush starts only after mem_resp and with mem_read low.
